window_buffer_gen: RTL and testbench

//   Upstream stage of the Sobel gradient units. Accepts a raster-order 8-bit pixel stream,

---
 rtl/window_buffer_gen.sv | 122 ++++++++++++
 tb/tb_window_buffer_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_buffer_gen.sv
// window_buffer_gen: turns a raster pixel stream into 3x3 neighbourhoods for the
// Sobel gradient blocks. Two line buffers hold the previous two image lines. A
// start_calculations pulse marks each new window that lies fully inside the image.
//
// state  | meaning
// IDLE   | waiting for frame_start; pixels ignored
// ACTIVE | accepting pixels, building windows
// DONE   | last pixel accepted; frame_done high for one cycle
module window_buffer_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 8
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      frame_start,
  input  logic [PIX_W-1:0]          pixel_in,
  input  logic                      pixel_valid,
  output logic [0:8][PIX_W-1:0]     windowBuffer,
  output logic                      start_calculations,
  output logic                      frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic [0:8][PIX_W-1:0]   win_q, win_d;
  logic                    start_q, start_d;
  logic [PIX_W-1:0]        lb0_q [0:IMG_WIDTH-1];
  logic [PIX_W-1:0]        lb1_q [0:IMG_WIDTH-1];

  logic accept;
  logic last_col;
  logic last_pix;

  // frame_start takes priority, so a pixel arriving with it is dropped
  assign accept   = pixel_valid && (state_q == ST_ACTIVE) && !frame_start;
  assign last_col = (col_q == COL_LAST);
  assign last_pix = last_col && (row_q == ROW_LAST);

  // next-state, counters, window shift and strobe
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    start_d = 1'b0;

    case (state_q)
      ST_IDLE:   if (frame_start) state_d = ST_ACTIVE;
      ST_ACTIVE: if (frame_start) state_d = ST_ACTIVE;
                 else if (accept && last_pix) state_d = ST_DONE;
      ST_DONE:   state_d = frame_start ? ST_ACTIVE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (frame_start) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (last_col) begin
        col_d = '0;
        // wrap the row at frame end so it never exceeds IMG_HEIGHT-1
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb1_q[col_q];
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb0_q[col_q];
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pixel_in;
      // only windows whose three columns all belong to the current line pair
      start_d  = (row_q >= RW'(2)) && (col_q >= CW'(2));
    end
  end

  // control and window registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      start_q <= start_d;
    end
  end

  // line buffers: lb0 holds the previous line, lb1 the one before; not reset
  // because every entry is rewritten before it is read into a strobed window
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= pixel_in;
    end
  end

  assign windowBuffer       = win_q;
  assign start_calculations = start_q;
  assign frame_done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_window_buffer_gen.sv
// Directed bench for window_buffer_gen on a 4x4 image with pixel value = raster index.
module tb_window_buffer_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             frame_start = 1'b0;
  logic             pixel_valid = 1'b0;
  logic [PW-1:0]    pixel_in = '0;
  logic [0:8][PW-1:0] windowBuffer;
  logic             start_calculations;
  logic             frame_done;

  int total = 0;
  int bad   = 0;

  logic [0:8][PW-1:0] wlog [0:15];
  int                 wpix [0:15];
  int                 n_str;
  logic               fd_last;
  int                 exp_pix [0:3] = '{10, 11, 14, 15};

  window_buffer_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .frame_start(frame_start),
    .pixel_in(pixel_in),
    .pixel_valid(pixel_valid),
    .windowBuffer(windowBuffer),
    .start_calculations(start_calculations),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // window expected after accepting pixel p at (row>=2, col>=2) of a 4-wide image
  function automatic logic [0:8][PW-1:0] exp_win(input int p);
    logic [0:8][PW-1:0] w;
    w[0] = 8'(p - 10); w[1] = 8'(p - 9); w[2] = 8'(p - 8);
    w[3] = 8'(p - 6);  w[4] = 8'(p - 5); w[5] = 8'(p - 4);
    w[6] = 8'(p - 2);  w[7] = 8'(p - 1); w[8] = 8'(p);
    return w;
  endfunction

  task automatic drive(input logic fs, input logic pv, input logic [PW-1:0] pix);
    @(negedge clk);
    frame_start = fs;
    pixel_valid = pv;
    pixel_in    = pix;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic log_strobe(input int p);
    if (start_calculations === 1'b1) begin
      if (n_str < 16) begin
        wlog[n_str] = windowBuffer;
        wpix[n_str] = p;
      end
      n_str++;
    end
  endtask

  task automatic send_pixels(input int first, input int last);
    for (int p = first; p <= last; p++) begin
      drive(1'b0, 1'b1, 8'(p));
      log_strobe(p);
      if (p == 15) fd_last = frame_done;
    end
  endtask

  task automatic run_frame();
    n_str   = 0;
    fd_last = 1'b0;
    drive(1'b1, 1'b0, 8'd0);
    send_pixels(0, 15);
    idle_cycle();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (windowBuffer !== '0) begin bad++; $display("FAIL reset_win: got %h want 0", windowBuffer); end
    total++; if (start_calculations !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", start_calculations); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", frame_done); end
    n_rst = 1'b1;
  endtask

  task automatic test_idle_pre();
    for (int p = 0; p < 4; p++) begin
      drive(1'b0, 1'b1, 8'(p + 50));
      total++; if (start_calculations !== 1'b0) begin bad++; $display("FAIL idle_pre_start p=%0d: got %b want 0", p, start_calculations); end
      total++; if (windowBuffer !== '0) begin bad++; $display("FAIL idle_pre_win p=%0d: got %h want 0", p, windowBuffer); end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_s;
    logic [0:8][PW-1:0] first_w;
    logic [0:8][PW-1:0] last_w;
    int cnt;
    first_w = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    last_w  = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
    cnt = 0;
    drive(1'b1, 1'b0, 8'd0);
    for (int p = 0; p < 16; p++) begin
      drive(1'b0, 1'b1, 8'(p));
      exp_s = ((p / W) >= 2) && ((p % W) >= 2);
      if (start_calculations === 1'b1) cnt++;
      total++; if (start_calculations !== exp_s) begin bad++; $display("FAIL b2b_start p=%0d: got %b want %b", p, start_calculations, exp_s); end
      if (exp_s) begin
        total++; if (windowBuffer !== exp_win(p)) begin bad++; $display("FAIL b2b_win p=%0d: got %h want %h", p, windowBuffer, exp_win(p)); end
      end
      if (p == 10) begin
        total++; if (windowBuffer !== first_w) begin bad++; $display("FAIL b2b_first_win: got %h want %h", windowBuffer, first_w); end
      end
      if (p == 15) begin
        total++; if (windowBuffer !== last_w) begin bad++; $display("FAIL b2b_last_win: got %h want %h", windowBuffer, last_w); end
      end
      total++; if (frame_done !== (p == 15)) begin bad++; $display("FAIL b2b_done p=%0d: got %b want %b", p, frame_done, (p == 15)); end
    end
    idle_cycle();
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL b2b_done_pulse: got %b want 0", frame_done); end
    total++; if (start_calculations !== 1'b0) begin bad++; $display("FAIL b2b_start_pulse: got %b want 0", start_calculations); end
    total++; if (cnt !== 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", cnt); end
  endtask

  task automatic test_stall();
    logic [0:8][PW-1:0] hold;
    int nstall;
    n_str   = 0;
    fd_last = 1'b0;
    drive(1'b1, 1'b0, 8'd0);
    for (int p = 0; p < 16; p++) begin
      drive(1'b0, 1'b1, 8'(p));
      log_strobe(p);
      if (p == 15) fd_last = frame_done;
      hold   = windowBuffer;
      nstall = ((p % 2) == 1 ? 1 : 0) + (p == 9 ? 7 : 0);
      for (int s = 0; s < nstall; s++) begin
        idle_cycle();
        total++; if (windowBuffer !== hold) begin bad++; $display("FAIL stall_hold p=%0d s=%0d: got %h want %h", p, s, windowBuffer, hold); end
        total++; if (start_calculations !== 1'b0) begin bad++; $display("FAIL stall_start p=%0d s=%0d: got %b want 0", p, s, start_calculations); end
      end
    end
    total++; if (n_str !== 4) begin bad++; $display("FAIL stall_count: got %0d want 4", n_str); end
    for (int k = 0; k < 4 && k < n_str; k++) begin
      total++; if (wpix[k] !== exp_pix[k]) begin bad++; $display("FAIL stall_pix k=%0d: got %0d want %0d", k, wpix[k], exp_pix[k]); end
      total++; if (wlog[k] !== exp_win(exp_pix[k])) begin bad++; $display("FAIL stall_win k=%0d: got %h want %h", k, wlog[k], exp_win(exp_pix[k])); end
    end
    total++; if (fd_last !== 1'b1) begin bad++; $display("FAIL stall_done: got %b want 1", fd_last); end
    idle_cycle();
  endtask

  task automatic test_row_boundary();
    drive(1'b1, 1'b0, 8'd0);
    for (int p = 0; p < 16; p++) begin
      drive(1'b0, 1'b1, 8'(p));
      if (p == 8 || p == 9 || p == 12 || p == 13) begin
        total++; if (start_calculations !== 1'b0) begin bad++; $display("FAIL row_edge_start p=%0d: got %b want 0", p, start_calculations); end
      end
      if (p == 10 || p == 14) begin
        total++; if (start_calculations !== 1'b1) begin bad++; $display("FAIL row_edge_first p=%0d: got %b want 1", p, start_calculations); end
      end
    end
    idle_cycle();
  endtask

  task automatic test_restart();
    n_str   = 0;
    fd_last = 1'b0;
    drive(1'b1, 1'b0, 8'd0);
    for (int p = 0; p <= 6; p++) drive(1'b0, 1'b1, 8'(p));
    drive(1'b1, 1'b1, 8'd99);
    total++; if (start_calculations !== 1'b0) begin bad++; $display("FAIL restart_start: got %b want 0", start_calculations); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL restart_done: got %b want 0", frame_done); end
    send_pixels(0, 15);
    total++; if (n_str !== 4) begin bad++; $display("FAIL restart_count: got %0d want 4", n_str); end
    for (int k = 0; k < 4 && k < n_str; k++) begin
      total++; if (wpix[k] !== exp_pix[k]) begin bad++; $display("FAIL restart_pix k=%0d: got %0d want %0d", k, wpix[k], exp_pix[k]); end
      total++; if (wlog[k] !== exp_win(exp_pix[k])) begin bad++; $display("FAIL restart_win k=%0d: got %h want %h", k, wlog[k], exp_win(exp_pix[k])); end
    end
    total++; if (fd_last !== 1'b1) begin bad++; $display("FAIL restart_frame_done: got %b want 1", fd_last); end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 8'd0);
    for (int p = 0; p <= 11; p++) drive(1'b0, 1'b1, 8'(p));
    total++; if (start_calculations !== 1'b1) begin bad++; $display("FAIL rstmid_pre_start: got %b want 1", start_calculations); end
    #2;
    n_rst = 1'b0;
    #1;
    total++; if (windowBuffer !== '0) begin bad++; $display("FAIL rstmid_win: got %h want 0", windowBuffer); end
    total++; if (start_calculations !== 1'b0) begin bad++; $display("FAIL rstmid_start: got %b want 0", start_calculations); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b want 0", frame_done); end
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    for (int p = 12; p <= 15; p++) begin
      drive(1'b0, 1'b1, 8'(p));
      total++; if (start_calculations !== 1'b0) begin bad++; $display("FAIL rstmid_ignored_start p=%0d: got %b want 0", p, start_calculations); end
      total++; if (windowBuffer !== '0) begin bad++; $display("FAIL rstmid_ignored_win p=%0d: got %h want 0", p, windowBuffer); end
    end
    run_frame();
    total++; if (n_str !== 4) begin bad++; $display("FAIL rstmid_count: got %0d want 4", n_str); end
    for (int k = 0; k < 4 && k < n_str; k++) begin
      total++; if (wlog[k] !== exp_win(exp_pix[k])) begin bad++; $display("FAIL rstmid_frame_win k=%0d: got %h want %h", k, wlog[k], exp_win(exp_pix[k])); end
    end
    total++; if (fd_last !== 1'b1) begin bad++; $display("FAIL rstmid_frame_done: got %b want 1", fd_last); end
  endtask

  task automatic test_idle_post();
    logic [0:8][PW-1:0] hold;
    hold = windowBuffer;
    for (int p = 0; p < 6; p++) begin
      drive(1'b0, 1'b1, 8'(200 + p));
      total++; if (start_calculations !== 1'b0) begin bad++; $display("FAIL idle_post_start p=%0d: got %b want 0", p, start_calculations); end
      total++; if (windowBuffer !== hold) begin bad++; $display("FAIL idle_post_win p=%0d: got %h want %h", p, windowBuffer, hold); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL idle_post_done p=%0d: got %b want 0", p, frame_done); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_pre();
    test_back_to_back();
    test_stall();
    test_row_boundary();
    test_restart();
    test_reset_mid();
    test_idle_post();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
